// File: rtl/image_stream_loader_if.sv
// Stream word interface into the image loader.
//   in_data  : signed W-bit word from the source
//   in_valid : in_data holds a word
//   in_last  : the word is meant to be the final word of the frame
//   in_ready : the loader accepts a word this cycle
// Handshake: a beat transfers on a rising clk edge where in_valid and
// in_ready are both 1. The source keeps in_data/in_last stable while
// in_valid is high and in_ready is low. in_ready does not depend on in_valid.
interface image_stream_loader_if #(
  parameter int W = 32
) ();
  logic signed [W-1:0] in_data;
  logic                in_valid;
  logic                in_last;
  logic                in_ready;

  modport master (output in_data, output in_valid, output in_last, input in_ready);
  modport slave  (input in_data, input in_valid, input in_last, output in_ready);
endinterface

// File: rtl/image_stream_loader.sv
// Serial-to-flat frame loader. Accepts ROWS*COLS signed words over a
// valid/ready stream and writes them row-major into a flat bus where word
// (r,c) sits at bits [COLS*W*r + W*c +: W].
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   i_start        : one-cycle pulse, begins a frame load (ignored in LOAD)
//   s_in           : stream slave (in_data, in_valid, in_last, in_ready)
//   o_data_f       : packed frame
//   o_data_valid   : o_data_f holds a complete frame
//   o_done         : one-cycle pulse when the frame completes
//   o_frame_err    : sticky, in_last was misplaced in the last frame
//   o_state        : current FSM state (debug)
module image_stream_loader #(
  parameter int ROWS = 28,
  parameter int COLS = 28,
  parameter int W    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_start,
  image_stream_loader_if.slave         s_in,
  output logic signed [ROWS*COLS*W-1:0] o_data_f,
  output logic                         o_data_valid,
  output logic                         o_done,
  output logic                         o_frame_err,
  output logic [1:0]                   o_state
);

  localparam int FLAT = ROWS * COLS * W;
  localparam int BW   = $clog2(FLAT);
  localparam int RW   = $clog2(ROWS);
  localparam int CW   = $clog2(COLS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [RW-1:0]           r_row;
  logic [CW-1:0]           r_col;
  logic signed [FLAT-1:0]  r_data_f;
  logic                    r_in_ready;
  logic                    r_data_valid;
  logic                    r_done;
  logic                    r_frame_err;

  logic                    w_accept;
  logic                    w_col_end;
  logic                    w_final;
  logic                    w_restart;
  logic [BW-1:0]           w_base;

  // Flat bit offset of the current word; fits BW bits for any legal row/col.
  assign w_base = BW'(r_row) * BW'(COLS * W) + BW'(r_col) * BW'(W);

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_restart    = 1'b0;
    w_col_end    = (r_col == CW'(COLS - 1));
    w_final      = (r_row == RW'(ROWS - 1)) && w_col_end;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next_state = S_LOAD;
          w_restart    = 1'b1;
        end
      end
      S_LOAD: begin
        // start is ignored here, including on the final beat.
        w_accept = s_in.in_valid && r_in_ready;
        if (w_accept && w_final) w_next_state = S_DONE;
      end
      S_DONE: begin
        if (i_start) begin
          w_next_state = S_LOAD;
          w_restart    = 1'b1;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_row        <= '0;
      r_col        <= '0;
      r_data_f     <= '0;
      r_in_ready   <= 1'b0;
      r_data_valid <= 1'b0;
      r_done       <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      // Ready follows the state we are entering, so it drops on the same
      // edge that takes the final beat and no extra beat can slip in.
      r_in_ready <= (w_next_state == S_LOAD);
      r_done     <= w_accept && w_final;

      if (w_restart) begin
        r_row        <= '0;
        r_col        <= '0;
        r_data_valid <= 1'b0;
        r_frame_err  <= 1'b0;
      end

      if (w_accept) begin
        r_data_f[w_base +: W] <= s_in.in_data;
        if (s_in.in_last != w_final) r_frame_err <= 1'b1;
        if (w_col_end) begin
          r_col <= '0;
          if (!w_final) r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
        if (w_final) r_data_valid <= 1'b1;
      end
    end
  end

  assign s_in.in_ready = r_in_ready;
  assign o_data_f      = r_data_f;
  assign o_data_valid  = r_data_valid;
  assign o_done        = r_done;
  assign o_frame_err   = r_frame_err;
  assign o_state       = r_state;

endmodule

// File: tb/tb_image_stream_loader.sv
module tb_image_stream_loader;

  localparam int ROWS = 28;
  localparam int COLS = 28;
  localparam int W    = 32;
  localparam int N    = ROWS * COLS;
  localparam int FLAT = N * W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [FLAT-1:0]  data_f;
  logic             data_valid;
  logic             done;
  logic             frame_err;
  logic [1:0]       dbg_state;

  image_stream_loader_if #(.W(W)) s_if ();

  image_stream_loader #(.ROWS(ROWS), .COLS(COLS), .W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (start),
    .s_in         (s_if.slave),
    .o_data_f     (data_f),
    .o_data_valid (data_valid),
    .o_done       (done),
    .o_frame_err  (frame_err),
    .o_state      (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- behavioural model ----------------
  // The frame is a linear list of N words; beat k lands in word k, which in
  // row-major order is word (k/COLS, k%COLS).
  logic [W-1:0] m_mem [N];
  int           m_cnt     = 0;
  bit           m_loading = 1'b0;
  bit           m_valid   = 1'b0;
  bit           m_done    = 1'b0;
  bit           m_err     = 1'b0;
  bit           m_live    = 1'b0;
  int           hs_count  = 0;
  int           done_count = 0;

  always @(posedge clk) begin
    if (s_if.in_valid && s_if.in_ready) hs_count++;
    if (done) done_count++;
    if (rst) begin
      for (int i = 0; i < N; i++) m_mem[i] = '0;
      m_cnt = 0; m_loading = 0; m_valid = 0; m_done = 0; m_err = 0;
      m_live = 1'b1;
    end else begin
      m_done = 1'b0;
      if (m_loading) begin
        if (s_if.in_valid) begin
          m_mem[m_cnt] = s_if.in_data;
          if (s_if.in_last != (m_cnt == N - 1)) m_err = 1'b1;
          if (m_cnt == N - 1) begin
            m_loading = 1'b0; m_valid = 1'b1; m_done = 1'b1;
          end
          m_cnt++;
        end
      end else if (start) begin
        m_loading = 1'b1; m_cnt = 0; m_valid = 1'b0; m_err = 1'b0;
      end
    end
  end

  function automatic logic [FLAT-1:0] pack_model();
    logic [FLAT-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = m_mem[i];
    return v;
  endfunction

  task automatic check1(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_frame(input string name, input logic [FLAT-1:0] exp);
    vectors++;
    if (data_f !== exp) begin
      int first = -1;
      for (int i = N - 1; i >= 0; i--) if (data_f[i*W +: W] !== exp[i*W +: W]) first = i;
      miscompares++;
      $display("FAIL %s: word %0d got %h expected %h at %0t", name, first,
               data_f[first*W +: W], exp[first*W +: W], $time);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (m_live) begin
      check1("in_ready",   {31'd0, s_if.in_ready}, {31'd0, m_loading});
      check1("data_valid", {31'd0, data_valid},    {31'd0, m_valid});
      check1("done",       {31'd0, done},          {31'd0, m_done});
      check1("frame_err",  {31'd0, frame_err},     {31'd0, m_err});
      check_frame("data_f", pack_model());
    end
  end

  // ---------------- driver ----------------
  function automatic logic [W-1:0] word_of(input int kind, input int i);
    if (kind == 2) return 32'h5A5A5A5A;
    if (kind == 1 && i == 0) return 32'hFFFF_FFFF;
    if (kind == 1 && i == 13*COLS + 5) return -32'sd123456;
    return W'(i);
  endfunction

  // Called at a negedge. Pulses start, then streams N words. kind selects
  // the data pattern; stall adds gaps; start_a/start_b pulse start with that
  // beat; abort_at asserts rst instead of sending that beat.
  task automatic load_frame(input int kind, input bit stall, input int last_pos,
                            input int start_a, input int start_b, input int abort_at);
    int i = 0;
    int guard = 0;
    bit v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (i < N && guard < 20000) begin
      if (i == abort_at) begin
        rst = 1'b1; s_if.in_valid = 1'b0; start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (!stall)      v = 1'b1;
      else if (i < 8)  v = (guard % 2 == 0);
      else             v = ($urandom_range(0, 2) != 0);
      s_if.in_valid = v;
      s_if.in_data  = word_of(kind, i);
      s_if.in_last  = (i == last_pos);
      start = v && s_if.in_ready && (i == start_a || i == start_b);
      if (v && s_if.in_ready) i++;
      @(negedge clk);
      guard++;
    end
    s_if.in_valid = 1'b0; s_if.in_last = 1'b0; start = 1'b0;
    vectors++;
    if (i < N) begin
      miscompares++;
      $display("FAIL load_timeout: beats sent %0d required %0d", i, N);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    s_if.in_valid = 1'b0;
    s_if.in_data  = '0;
    s_if.in_last  = 1'b0;
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    check1("rst_in_ready",   {31'd0, s_if.in_ready}, 32'd0);
    check1("rst_data_valid", {31'd0, data_valid},    32'd0);
    check1("rst_frame_err",  {31'd0, frame_err},     32'd0);
    check_frame("rst_data_f", '0);

    // 1: full frame, no stalls, in_last on the final word
    hs_count = 0;
    load_frame(0, 1'b0, N - 1, -1, -1, -1);
    check1("t1_done",      {31'd0, done},       32'd1);
    check1("t1_valid",     {31'd0, data_valid}, 32'd1);
    check1("t1_ready_off", {31'd0, s_if.in_ready}, 32'd0);
    check1("t1_beats",     hs_count,            32'd784);
    check1("t1_w0",        data_f[0 +: 32],     32'd0);
    check1("t1_w783",      data_f[896*27 + 32*27 +: 32], 32'd783);
    check1("t1_err",       {31'd0, frame_err},  32'd0);
    idle(1);
    check1("t1_done_pulse", {31'd0, done},      32'd0);
    idle(2);

    // 2: same frame with stalls
    hs_count = 0;
    load_frame(0, 1'b1, N - 1, -1, -1, -1);
    idle(1);
    begin
      logic [FLAT-1:0] e;
      for (int i = 0; i < N; i++) e[i*W +: W] = W'(i);
      check_frame("t2_frame", e);
    end
    check1("t2_beats", hs_count, 32'd784);

    // 3: negative words
    load_frame(1, 1'b0, N - 1, -1, -1, -1);
    idle(1);
    check1("t3_w00",   data_f[0 +: 32],                32'hFFFF_FFFF);
    check1("t3_w13_5", data_f[896*13 + 32*5 +: 32],    32'hFFFE_1DC0);
    check1("t3_w13_4", data_f[896*13 + 32*4 +: 32],    32'd368);
    check1("t3_w13_6", data_f[896*13 + 32*6 +: 32],    32'd370);
    check1("t3_w01",   data_f[32 +: 32],               32'd1);

    // 4: in_last misplaced on beat 100
    done_count = 0;
    load_frame(0, 1'b0, 100, -1, -1, -1);
    idle(1);
    check1("t4_err",  {31'd0, frame_err}, 32'd1);
    check1("t4_done", done_count,         32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check1("t4_err_clr", {31'd0, frame_err}, 32'd0);
    // finish this frame properly so the block sits in DONE again
    begin
      int i = 0;
      int g = 0;
      while (i < N && g < 2000) begin
        s_if.in_valid = 1'b1; s_if.in_data = W'(i); s_if.in_last = (i == N - 1);
        if (s_if.in_ready) i++;
        @(negedge clk); g++;
      end
      s_if.in_valid = 1'b0; s_if.in_last = 1'b0;
    end
    idle(1);

    // 5: reset after 400 beats
    load_frame(0, 1'b0, N - 1, -1, -1, 400);
    check_frame("t5_data_f_zero", '0);
    check1("t5_ready", {31'd0, s_if.in_ready}, 32'd0);
    check1("t5_valid", {31'd0, data_valid},    32'd0);
    idle(2);
    load_frame(0, 1'b0, N - 1, -1, -1, -1);
    check1("t5_reload_valid", {31'd0, data_valid}, 32'd1);
    idle(2);

    // 6: start during LOAD and with the final beat, then reload in DONE
    done_count = 0;
    load_frame(0, 1'b0, N - 1, 50, N - 1, -1);
    idle(3);
    check1("t6_single_done", done_count,          32'd1);
    check1("t6_valid",       {31'd0, data_valid}, 32'd1);
    load_frame(2, 1'b0, N - 1, -1, -1, -1);
    idle(1);
    begin
      int bad = 0;
      for (int i = 0; i < N; i++) if (data_f[i*W +: W] !== 32'h5A5A5A5A) bad++;
      check1("t6_5a_bad_words", bad, 32'd0);
    end
    check1("t6_err", {31'd0, frame_err}, 32'd0);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
